// File: rtl/param_counter.sv
// Up/down counter with a programmable upper bound, wrap or saturate
// at either end, a one-cycle wrap pulse and a sticky boundary flag.
module param_counter #(
  parameter int unsigned      WIDTH   = 4,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             sat_i,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] ld_val_i,
  input  logic             clr_ovf_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             wrap_o,
  output logic             ovf_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;

  logic             at_max;
  logic             at_min;
  logic             hit;
  logic [WIDTH-1:0] ld_clip;

  // Boundary detection and clamped load value.
  always_comb begin
    at_max  = (cnt_q >= MAX_VAL);
    at_min  = (cnt_q == '0);
    ld_clip = (ld_val_i > MAX_VAL) ? MAX_VAL : ld_val_i;
  end

  // Next-state: load beats enable; a boundary step either wraps or holds.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    hit    = 1'b0;
    if (ld_i) begin
      cnt_d = ld_clip;
    end else if (en_i) begin
      if (up_i) begin
        if (at_max) begin
          hit = 1'b1;
          if (!sat_i) begin
            cnt_d  = '0;
            wrap_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        if (at_min) begin
          hit = 1'b1;
          if (!sat_i) begin
            cnt_d  = MAX_VAL;
            wrap_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
    end
    // A fresh boundary hit wins over a coincident clear.
    ovf_d = hit | (ovf_q & ~clr_ovf_i);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  // Outputs: registered state plus a combinational zero detect.
  always_comb begin
    cnt_o  = cnt_q;
    wrap_o = wrap_q;
    ovf_o  = ovf_q;
    zero_o = (cnt_q == '0);
  end

endmodule

// File: tb/tb_param_counter.sv
// Bench for param_counter: three bounds (15, 9, 1) share one stimulus
// stream; a table, directed sequences and random cycles are checked.
module tb_param_counter;

  logic       clk = 1'b0;
  logic       rst_n, en, up, sat, ld, clr;
  logic [3:0] ldv;

  logic [3:0] cnt_a [3];
  logic       wrap_a[3];
  logic       ovf_a [3];
  logic       zero_a[3];

  int maxv[3] = '{15, 9, 1};
  int m_cnt[3];
  int m_wrap[3];
  int m_ovf[3];

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam logic [3:0] MV = (k == 0) ? 4'd15 :
                                (k == 1) ? 4'd9 : 4'd1;
    param_counter #(
      .WIDTH  (4),
      .MAX_VAL(MV)
    ) u_dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .en_i     (en),
      .up_i     (up),
      .sat_i    (sat),
      .ld_i     (ld),
      .ld_val_i (ldv),
      .clr_ovf_i(clr),
      .cnt_o    (cnt_a[k]),
      .wrap_o   (wrap_a[k]),
      .ovf_o    (ovf_a[k]),
      .zero_o   (zero_a[k])
    );
  end

  // Reference: plain integer step, wrap via arithmetic modulo MAX+1.
  function automatic void model_step(int k);
    int nxt, m, nw, nov;
    m = maxv[k] + 1;
    if (!rst_n) begin
      m_cnt[k] = 0; m_wrap[k] = 0; m_ovf[k] = 0;
      return;
    end
    nw  = 0;
    nov = (m_ovf[k] != 0) && !clr;
    if (ld) begin
      m_cnt[k] = (int'(ldv) > maxv[k]) ? maxv[k] : int'(ldv);
    end else if (en) begin
      nxt = m_cnt[k] + (up ? 1 : -1);
      if (nxt < 0 || nxt > maxv[k]) begin
        nov = 1;
        if (!sat) begin
          nw = 1;
          m_cnt[k] = ((nxt % m) + m) % m;
        end
      end else begin
        m_cnt[k] = nxt;
      end
    end
    m_wrap[k] = nw;
    m_ovf[k]  = nov;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_tot++;
    if (act != exp)
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("cnt_m%0d", maxv[k]), int'(cnt_a[k]), m_cnt[k]);
      chk($sformatf("wrap_m%0d", maxv[k]), int'(wrap_a[k]), m_wrap[k]);
      chk($sformatf("ovf_m%0d", maxv[k]), int'(ovf_a[k]), m_ovf[k]);
      chk($sformatf("zero_m%0d", maxv[k]), int'(zero_a[k]),
          (m_cnt[k] == 0) ? 1 : 0);
    end
  endtask

  // One clock: model steps on the edge, outputs sampled 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k);
    #1;
    check_all();
  endtask

  task automatic drive(logic r, logic l, logic [3:0] lv, logic e,
                       logic u, logic s, logic c);
    rst_n = r; ld = l; ldv = lv; en = e; up = u; sat = s; clr = c;
  endtask

  typedef struct {
    logic       rst, ld;
    logic [3:0] ldv;
    logic       en, up, sat, clr;
    int         e_cnt, e_wrap, e_ovf;
  } vec_t;

  vec_t tbl[18];

  initial begin
    // Hand-derived expectations for the MAX_VAL=9 instance.
    tbl[0]  = '{0,0,0, 0,0,0,0, 0,0,0};
    tbl[1]  = '{1,1,2, 0,0,0,0, 2,0,0};
    tbl[2]  = '{1,0,0, 1,0,1,0, 1,0,0};
    tbl[3]  = '{1,0,0, 1,0,1,0, 0,0,0};
    tbl[4]  = '{1,0,0, 1,0,1,0, 0,0,1};
    tbl[5]  = '{1,0,0, 1,0,1,0, 0,0,1};
    tbl[6]  = '{1,1,13,0,0,0,0, 9,0,1};
    tbl[7]  = '{1,1,3, 1,1,0,0, 3,0,1};
    tbl[8]  = '{1,0,0, 0,1,0,1, 3,0,0};
    tbl[9]  = '{1,1,9, 0,1,0,0, 9,0,0};
    tbl[10] = '{1,0,0, 1,1,0,1, 0,1,1};
    tbl[11] = '{1,0,0, 0,1,0,0, 0,0,1};
    tbl[12] = '{1,0,0, 1,0,0,0, 9,1,1};
    tbl[13] = '{1,1,7, 0,1,0,0, 7,0,1};
    tbl[14] = '{0,0,0, 1,1,0,0, 0,0,0};
    tbl[15] = '{1,0,0, 1,1,0,0, 1,0,0};
    tbl[16] = '{1,0,0, 1,1,0,0, 2,0,0};
    tbl[17] = '{1,0,0, 1,0,0,0, 1,0,0};

    foreach (m_cnt[k]) begin
      m_cnt[k] = 0; m_wrap[k] = 0; m_ovf[k] = 0;
    end
    drive(0, 0, 0, 0, 1, 0, 0);
    cyc();

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].rst, tbl[i].ld, tbl[i].ldv, tbl[i].en,
            tbl[i].up, tbl[i].sat, tbl[i].clr);
      cyc();
      chk($sformatf("tbl%0d_cnt", i), int'(cnt_a[1]), tbl[i].e_cnt);
      chk($sformatf("tbl%0d_wrap", i), int'(wrap_a[1]), tbl[i].e_wrap);
      chk($sformatf("tbl%0d_ovf", i), int'(ovf_a[1]), tbl[i].e_ovf);
    end

    // Full upward sweep on bound 15; bound 1 wraps every other cycle.
    drive(0, 0, 0, 0, 1, 0, 0);
    cyc();
    chk("rst_ovf15", int'(ovf_a[0]), 0);
    drive(1, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 16; i++) begin
      cyc();
      chk($sformatf("sweep15_cnt%0d", i), int'(cnt_a[0]), (i + 1) % 16);
      chk($sformatf("sweep15_wrap%0d", i), int'(wrap_a[0]),
          (i == 15) ? 1 : 0);
      chk($sformatf("alt1_cnt%0d", i), int'(cnt_a[2]), (i + 1) % 2);
      chk($sformatf("alt1_wrap%0d", i), int'(wrap_a[2]), i % 2);
    end
    chk("sweep15_ovf", int'(ovf_a[0]), 1);
    drive(1, 0, 0, 0, 1, 0, 0);
    cyc();
    chk("sweep15_wrap_drop", int'(wrap_a[0]), 0);

    // Reset landing on a wrap pulse must leave nothing behind.
    drive(1, 1, 15, 0, 1, 0, 0);
    cyc();
    drive(1, 0, 0, 1, 1, 0, 0);
    cyc();
    chk("pre_rst_wrap15", int'(wrap_a[0]), 1);
    drive(0, 0, 0, 1, 1, 0, 1);
    cyc();
    chk("rst_wrap15", int'(wrap_a[0]), 0);
    chk("rst_ovf15b", int'(ovf_a[0]), 0);
    chk("rst_cnt15", int'(cnt_a[0]), 0);

    // Randomized stream against the reference model.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 39) != 0),
            ($urandom_range(0, 9) == 0),
            4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0));
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/param_counter.md
PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits (legal range 2..32).
REQ-002 SHALL have parameter MAX_VAL, default 2**WIDTH-1, upper count bound and modulus minus one (legal range 1..2**WIDTH-1).
REQ-003 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port en_i  input  1  count enable; one step per cycle while high.
REQ-006 SHALL have port up_i  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 SHALL have port sat_i  input  1  mode: 0 = wrap at bounds, 1 = saturate at bounds.
REQ-008 SHALL have port ld_i  input  1  synchronous load strobe.
REQ-009 SHALL have port ld_val_i  input  WIDTH  load value.
REQ-010 SHALL have port clr_ovf_i  input  1  clears the sticky overflow flag.
REQ-011 SHALL have port cnt_o  output  WIDTH  registered count value.
REQ-012 SHALL have port wrap_o  output  1  registered one-cycle pulse marking a wrap event.
REQ-013 SHALL have port ovf_o  output  1  registered sticky boundary-hit flag.
REQ-014 SHALL have port zero_o  output  1  combinational, high when cnt_o == 0.

Function
REQ-015 Per-cycle priority SHALL be: reset > ld_i > en_i > hold.
REQ-016 ld_i high: cnt_o SHALL take ld_val_i next cycle; if ld_val_i > MAX_VAL, cnt_o SHALL take MAX_VAL; no wrap_o or ovf_o effect.
REQ-017 en_i high, up_i=1, cnt_o < MAX_VAL: cnt_o SHALL become cnt_o+1 next cycle.
REQ-018 en_i high, up_i=0, cnt_o > 0: cnt_o SHALL become cnt_o-1 next cycle.
REQ-019 Up at MAX_VAL, sat_i=0: cnt_o SHALL become 0, wrap_o SHALL pulse high for exactly the next cycle, ovf_o SHALL set.
REQ-020 Down at 0, sat_i=0: cnt_o SHALL become MAX_VAL, wrap_o SHALL pulse high for the next cycle, ovf_o SHALL set.
REQ-021 Up at MAX_VAL or down at 0 with sat_i=1: cnt_o SHALL hold, wrap_o SHALL stay low, ovf_o SHALL set.
REQ-022 wrap_o SHALL be low in every cycle not immediately following a wrap event; back-to-back wraps (MAX_VAL=1) SHALL yield wrap_o high on consecutive cycles.
REQ-023 ovf_o SHALL remain high until clr_ovf_i or reset; if clr_ovf_i and a new boundary hit coincide, ovf_o SHALL be high next cycle (set wins).
REQ-024 en_i low and ld_i low: cnt_o SHALL hold; wrap_o SHALL be low next cycle.
REQ-025 sat_i and up_i SHALL be sampled each cycle; changing them mid-count SHALL take effect on that cycle's step with no pipeline delay.
REQ-026 Arithmetic SHALL be modulo MAX_VAL+1; cnt_o SHALL never exceed MAX_VAL in any cycle after reset.
REQ-027 Step latency SHALL be one cycle from sampled en_i/ld_i to updated cnt_o.

Reset
REQ-028 rst_ni low at a rising edge SHALL force cnt_o=0, wrap_o=0, ovf_o=0 next cycle, overriding ld_i, en_i and clr_ovf_i.
REQ-029 Reset asserted mid-count or during a wrap_o pulse SHALL abort it; no pulse or flag SHALL survive reset.
REQ-030 First step after rst_ni deasserts SHALL occur on the first edge with rst_ni high and en_i or ld_i high.

Verification
REQ-031 WIDTH=4, MAX_VAL=15, sat_i=0, up: 16 enabled cycles from 0 -> cnt_o 1..15 then 0, wrap_o high 1 cycle, ovf_o=1.
REQ-032 WIDTH=4, MAX_VAL=9, sat_i=1, down from ld_val_i=2: 4 enabled cycles -> cnt_o 1,0,0,0, wrap_o never high, ovf_o=1, zero_o=1.
REQ-033 MAX_VAL=9, ld_i with ld_val_i=13 -> cnt_o=9, ovf_o unchanged; then ld_i and en_i together with ld_val_i=3 -> cnt_o=3.
REQ-034 ovf_o=1, clr_ovf_i with no boundary hit -> ovf_o=0; clr_ovf_i coinciding with wrap -> ovf_o=1.
REQ-035 cnt_o=7, en_i high, rst_ni low one cycle -> cnt_o=0, wrap_o=0, ovf_o=0; counting resumes 1,2 after release.
REQ-036 MAX_VAL=1, sat_i=0, up continuous -> cnt_o alternates 1,0, wrap_o high every other cycle.
